// File: rtl/serial_work_transmit_pkg.sv
// Shared definitions for the serial work path: packet geometry, default guard
// length and the transmit FSM encoding.
package serial_work_transmit_pkg;

  localparam int unsigned WORK_BYTES           = 64;
  localparam int unsigned WORK_BITS            = 512;
  localparam int unsigned DEFAULT_GUARD_CYCLES = 65536;
  localparam int unsigned GUARD_CNT_W          = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_READY,
    ST_DONE
  } tx_state_t;

  // Byte idx of the packet, MSB byte first; 63-idx is ~idx for a 6-bit index.
  function automatic logic [7:0] work_byte(input logic [WORK_BITS-1:0] work,
                                           input logic [5:0]           idx);
    logic [8:0] base;
    base = {~idx, 3'b000};
    return work[base +: 8];
  endfunction

endpackage

// File: rtl/serial_work_transmit_if.sv
// Work-send handshake between a work source and serial_work_transmit.
interface serial_work_transmit_if;

  logic         send;
  logic [255:0] midstate;
  logic [255:0] data2;
  logic         busy;
  logic         done;

  modport master (output send, midstate, data2, input busy, done);
  modport slave  (input send, midstate, data2, output busy, done);

endinterface

// File: rtl/serial_work_transmit_uart.sv
// uart_transmitter: 8N1 byte transmitter, no reset; tx_ready high when idle.
// Counters use >= so that arbitrary power-up contents drain within one frame.
module uart_transmitter #(
  parameter int unsigned comm_clk_frequency = 109_000_000,
  parameter int unsigned baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       rx_new_byte,
  input  logic [7:0] rx_byte,
  output logic       TxD,
  output logic       tx_ready
);

  localparam int unsigned DIV = (comm_clk_frequency / baud_rate) > 0 ?
                                (comm_clk_frequency / baud_rate) : 1;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  logic        active;
  logic [15:0] div_cnt;
  logic [3:0]  bit_idx;
  logic [9:0]  shreg;

  always_ff @(posedge clk) begin
    if (!active) begin
      div_cnt <= '0;
      bit_idx <= '0;
      if (rx_new_byte) begin
        shreg  <= {1'b1, rx_byte, 1'b0};
        active <= 1'b1;
      end
    end else if (div_cnt >= DIV_LAST) begin
      div_cnt <= '0;
      shreg   <= {1'b1, shreg[9:1]};
      if (bit_idx >= 4'd9) begin
        active <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  assign TxD      = active ? shreg[0] : 1'b1;
  assign tx_ready = !active;

endmodule

// File: rtl/serial_work_transmit.sv
// serial_work_transmit: sends the 64-byte {midstate,data2} packet MSB byte first
// over UART after an idle guard gap. Define SERIAL_WORK_LATCH_EN to register the
// work at send acceptance; otherwise inputs must stay stable until done.
module serial_work_transmit
  import serial_work_transmit_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 109_000_000,
  parameter int unsigned GUARD_CYCLES       = DEFAULT_GUARD_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_work_transmit_if.slave  bus,
  output logic                   TxD
);

  localparam logic [GUARD_CNT_W-1:0] GUARD_MAX  = GUARD_CNT_W'(GUARD_CYCLES);
  localparam logic [6:0]             LAST_COUNT = 7'(WORK_BYTES);

  tx_state_t               state, state_nx;
  logic [6:0]              cnt, cnt_nx;
  logic [GUARD_CNT_W-1:0]  guard_cnt;
  logic                    start_q, start_nx;
  logic [7:0]              byte_q, byte_nx;
  logic [7:0]              cur_byte;
  logic                    tx_ready;

`ifdef SERIAL_WORK_LATCH_EN
  logic [WORK_BITS-1:0] work_q, work_nx;

  always_comb begin
    work_nx = work_q;
    if (state == ST_IDLE && bus.send) begin
      work_nx = {bus.midstate, bus.data2};
    end else if (state == ST_SEND) begin
      work_nx = {work_q[WORK_BITS-9:0], 8'h00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
    end else begin
      work_q <= work_nx;
    end
  end

  assign cur_byte = work_q[WORK_BITS-1 -: 8];
`else
  assign cur_byte = work_byte({bus.midstate, bus.data2}, cnt[5:0]);
`endif

  // Counts only while the UART line is idle, so the gap is measured from the
  // end of the last stop bit rather than from the last strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt <= '0;
    end else if (start_q || !tx_ready) begin
      guard_cnt <= '0;
    end else if (guard_cnt != GUARD_MAX) begin
      guard_cnt <= guard_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      start_q <= start_nx;
      byte_q  <= byte_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start_nx = 1'b0;
    byte_nx  = byte_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.send) begin
          state_nx = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_cnt == GUARD_MAX && tx_ready) begin
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        start_nx = 1'b1;
        byte_nx  = cur_byte;
        cnt_nx   = cnt + 7'd1;
        state_nx = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_nx = ST_WAIT_READY;
        end
      end
      ST_WAIT_READY: begin
        if (tx_ready) begin
          state_nx = (cnt == LAST_COUNT) ? ST_DONE : ST_SEND;
        end
      end
      ST_DONE: begin
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.busy = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done = (state == ST_DONE);

  uart_transmitter #(
    .comm_clk_frequency (comm_clk_frequency)
  ) u_uart (
    .clk         (clk),
    .rx_new_byte (start_q),
    .rx_byte     (byte_q),
    .TxD         (TxD),
    .tx_ready    (tx_ready)
  );

endmodule

// File: tb/tb_serial_work_transmit.sv
// Directed bench for serial_work_transmit: UART monitor on TxD, packet vector
// table, plus hand sequences for send-at-done and reset mid-packet.
module tb_serial_work_transmit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd;

  serial_work_transmit_if wif ();

  serial_work_transmit #(
    .comm_clk_frequency (1_152_000),
    .GUARD_CYCLES       (200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wif.slave),
    .TxD   (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int line_free = 0;
  logic [7:0] rx_q[$];
  int         st_q[$];

  always @(posedge clk) if (wif.done === 1'b1) done_cnt <= done_cnt + 1;

  // UART monitor: 10 clk per bit, samples mid-bit on the falling clock edge.
  initial begin
    forever begin
      logic [7:0] b;
      int s;
      @(negedge txd);
      s = cyc;
      repeat (5) @(negedge clk);
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = txd;
        end
        repeat (10) @(negedge clk);
        if (txd === 1'b1) begin
          rx_q.push_back(b);
          st_q.push_back(s);
        end
        line_free = s + 100;
      end
    end
  end

  typedef struct {
    logic [255:0] mid;
    logic [255:0] d2;
    logic [7:0]   first;
    logic [7:0]   last;
    int           hold;
    bit           at_done;
  } vec_t;

  vec_t vec[4];

  task automatic chk(input string name, input bit ok, input longint got, input longint exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [255:0] m, input logic [255:0] d, input int k);
    logic [511:0] w;
    w = {m, d};
    return w[511 - 8*k -: 8];
  endfunction

  // Called at a falling edge; returns at the falling edge one cycle after done.
  task automatic do_packet(input int v);
    int S, ref_end, d0, t, bad, gmin, gmax, hi;
    logic [7:0] g_first, g_last, g_bad, e_bad;
    rx_q.delete();
    st_q.delete();
    d0 = done_cnt;
    ref_end = line_free;
    S = cyc;
    wif.midstate = vec[v].mid;
    wif.data2    = vec[v].d2;
    wif.send     = 1'b1;
    @(negedge clk);
    chk($sformatf("busy_rise[%0d]", v), wif.busy === 1'b1, longint'(wif.busy), 1);
`ifdef SERIAL_WORK_LATCH_EN
    wif.midstate = '1;
    wif.data2    = '1;
`endif
    if (vec[v].hold > 1) repeat (vec[v].hold - 1) @(negedge clk);
    wif.send = 1'b0;
    t = 0;
    while (wif.done !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("done_wait[%0d]", v), t < 20000, t, 20000);
    if (vec[v].at_done) wif.send = 1'b1;
    @(negedge clk);
    wif.send = 1'b0;
    chk($sformatf("done_pulse[%0d]", v), wif.done === 1'b0 && wif.busy === 1'b0,
        {wif.done, wif.busy}, 0);
    chk($sformatf("done_count[%0d]", v), done_cnt - d0 == 1, done_cnt - d0, 1);
    chk($sformatf("byte_count[%0d]", v), rx_q.size() == 64, rx_q.size(), 64);
    bad = -1;
    g_bad = 8'h00;
    e_bad = 8'h00;
    for (int k = 0; k < 64; k++) begin
      if (bad < 0 && (k >= rx_q.size() || rx_q[k] !== exp_byte(vec[v].mid, vec[v].d2, k))) begin
        bad = k;
        g_bad = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
        e_bad = exp_byte(vec[v].mid, vec[v].d2, k);
      end
    end
    chk($sformatf("bytes[%0d] idx %0d", v, bad), bad < 0, g_bad, e_bad);
    g_first = (rx_q.size() > 0)  ? rx_q[0]  : 8'hxx;
    g_last  = (rx_q.size() > 63) ? rx_q[63] : 8'hxx;
    chk($sformatf("first_byte[%0d]", v), g_first === vec[v].first, g_first, vec[v].first);
    chk($sformatf("last_byte[%0d]", v),  g_last  === vec[v].last,  g_last,  vec[v].last);
    if (st_q.size() > 0) begin
      hi = ((S + 4 > ref_end + 203) ? S + 4 : ref_end + 203) + 3;
      chk($sformatf("guard_gap[%0d]", v), st_q[0] - ref_end >= 200 && st_q[0] <= hi,
          st_q[0] - ref_end, 200);
    end else begin
      chk($sformatf("guard_gap[%0d]", v), 1'b0, 0, 200);
    end
    gmin = 1000;
    gmax = 0;
    for (int k = 1; k < st_q.size(); k++) begin
      if (st_q[k] - st_q[k-1] < gmin) gmin = st_q[k] - st_q[k-1];
      if (st_q[k] - st_q[k-1] > gmax) gmax = st_q[k] - st_q[k-1];
    end
    chk($sformatf("byte_spacing_max[%0d]", v), gmax <= 104, gmax, 104);
    chk($sformatf("byte_spacing_min[%0d]", v), gmin >= 100, gmin, 100);
    wif.midstate = vec[v].mid;
    wif.data2    = vec[v].d2;
  endtask

  initial begin
    int d0, t, nst;
    vec[0] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f,
               8'h00, 8'h3f, 1, 1'b0};
    vec[1] = '{{256{1'b1}}, 256'h0, 8'hff, 8'h00, 5000, 1'b0};
    vec[2] = '{{8{32'hdeadbeef}}, {8{32'h01234567}}, 8'hde, 8'h67, 1, 1'b0};
    vec[3] = '{{8'h80, 248'h0}, {248'h0, 8'h01}, 8'h80, 8'h01, 1, 1'b1};

    wif.send = 1'b0;
    wif.midstate = '0;
    wif.data2 = '0;
    repeat (5) @(negedge clk);
    chk("reset_busy", wif.busy === 1'b0, longint'(wif.busy), 0);
    chk("reset_done", wif.done === 1'b0, longint'(wif.done), 0);
    chk("reset_txd",  txd === 1'b1,      longint'(txd), 1);
    rst_n = 1'b1;
    line_free = cyc;
    repeat (300) @(negedge clk);

    // Back-to-back packets; the last one also pulses send during DONE.
    for (int v = 0; v < 4; v++) do_packet(v);

    nst = st_q.size();
    repeat (400) @(negedge clk);
    chk("send_at_done_ignored_busy", wif.busy === 1'b0, longint'(wif.busy), 0);
    chk("send_at_done_ignored_line", st_q.size() == nst, st_q.size(), nst);

    // Reset at byte 17, then a fresh packet must go out intact after the guard.
    rx_q.delete();
    st_q.delete();
    wif.midstate = vec[2].mid;
    wif.data2    = vec[2].d2;
    wif.send = 1'b1;
    @(negedge clk);
    wif.send = 1'b0;
    t = 0;
    while (rx_q.size() < 17 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_byte17", t < 20000, t, 20000);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_busy", wif.busy === 1'b0 && wif.done === 1'b0, {wif.busy, wif.done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    if (cyc > line_free) line_free = cyc;
    repeat (300) @(negedge clk);
    chk("reset_no_done", done_cnt == d0, done_cnt - d0, 0);
    chk("reset_idle_busy", wif.busy === 1'b0, longint'(wif.busy), 0);
    chk("reset_truncated", rx_q.size() < 64, rx_q.size(), 17);
    do_packet(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
